data_mem_responder: RTL and testbench

//  Responder end of the MEM-stage data-memory interface. Accepts load/store requests
//  (MemRead/MemWrite, ByteSel, Address, WriteData), models a fixed-latency data RAM, and

---
 rtl/mem_pkg.sv | 23 ++
 rtl/byte_lane_align.sv | 58 +++++
 rtl/data_mem_responder.sv | 198 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM-stage data-memory responder:
//   - ByteSel access-size codes (BS_WORD / BS_HALF / BS_BYTE; code 2'b11 is
//     reserved and handled as a word access)
//   - responder FSM state encoding (ST_IDLE / ST_BUSY / ST_RESP)
//   - LAT_W, the width of the latency down-counter (covers LATENCY 1..15)
// ---------------------------------------------------------------------------
package mem_pkg;

   localparam logic [1:0] BS_WORD = 2'b00;
   localparam logic [1:0] BS_HALF = 2'b01;
   localparam logic [1:0] BS_BYTE = 2'b10;

   localparam int LAT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_RESP = 2'b10
   } state_t;

endpackage

// File: rtl/byte_lane_align.sv
// ---------------------------------------------------------------------------
// byte_lane_align
// Purely combinational lane steering for little-endian sub-word accesses.
//   byte_sel    in   2   access size code (see mem_pkg)
//   sign_ext    in   1   loads: sign-extend (1) or zero-extend (0)
//   addr_lo     in   2   Address[1:0] of the access
//   write_data  in   32  store data, right-justified
//   ram_word    in   32  RAM word currently addressed
//   load_data   out  32  selected lane shifted to bit 0 and extended
//   lane_en     out  4   per-byte write enables for a store
//   store_word  out  32  store data replicated into every lane
//   misaligned  out  1   access is not naturally aligned
// ---------------------------------------------------------------------------
module byte_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  byte_sel,
   input  logic        sign_ext,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] write_data,
   input  logic [31:0] ram_word,
   output logic [31:0] load_data,
   output logic [3:0]  lane_en,
   output logic [31:0] store_word,
   output logic        misaligned
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // The store data is replicated into every lane so the write only has to
   // pick lanes with lane_en; the reserved size code falls through to word.
   always_comb begin
      sel_byte   = ram_word[{addr_lo, 3'b000} +: 8];
      sel_half   = addr_lo[1] ? ram_word[31:16] : ram_word[15:0];
      load_data  = ram_word;
      lane_en    = 4'b1111;
      store_word = write_data;
      misaligned = (addr_lo != 2'b00);
      case (byte_sel)
         BS_BYTE: begin
            load_data  = {{24{sign_ext & sel_byte[7]}}, sel_byte};
            lane_en    = 4'b0001 << addr_lo;
            store_word = {4{write_data[7:0]}};
            misaligned = 1'b0;
         end
         BS_HALF: begin
            load_data  = {{16{sign_ext & sel_half[15]}}, sel_half};
            lane_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
            store_word = {2{write_data[15:0]}};
            misaligned = addr_lo[0];
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Responder end of the MEM-stage data-memory interface: accepts a load or
// store, waits LATENCY cycles, commits to the word RAM and returns a one-cycle
// Ready pulse with aligned/extended load data.
//   Clock       in   1   pipeline clock
//   Reset       in   1   synchronous, active-high
//   MemRead     in   1   load request
//   MemWrite    in   1   store request (wins when both are set)
//   ByteSel     in   2   00 word, 01 half, 10 byte, 11 treated as word
//   SignExt     in   1   sub-word load extension select
//   Address     in   32  byte address (upper bits ignored, index wraps)
//   WriteData   in   32  store data, right-justified
//   ReadData    out  32  load result, non-zero only with Ready
//   Ready       out  1   one-cycle completion pulse
//   Stall       out  1   combinational pipeline hold
//   Misaligned  out  1   qualifies Ready: access was rejected as misaligned
// ---------------------------------------------------------------------------
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
)(
   input  logic        Clock,
   input  logic        Reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  ByteSel,
   input  logic        SignExt,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Stall,
   output logic        Misaligned
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [LAT_W-1:0] CNT_INIT = (LATENCY > 1) ? LAT_W'(LATENCY - 2) : '0;

   state_t             state;
   state_t             next_state;
   logic [LAT_W-1:0]   cnt;
   logic [LAT_W-1:0]   cnt_next;
   logic               req;
   logic               accept;
   logic               enter_resp;

   logic               store_q;
   logic [1:0]         byte_sel_q;
   logic               sign_ext_q;
   logic [IDX_W+1:0]   addr_q;
   logic [31:0]        wdata_q;

   logic               in_idle;
   logic               cur_store;
   logic [1:0]         cur_byte_sel;
   logic               cur_sign_ext;
   logic [IDX_W+1:0]   cur_addr;
   logic [31:0]        cur_wdata;
   logic [IDX_W-1:0]   word_idx;

   logic [31:0]        ram_word;
   logic [31:0]        load_data;
   logic [3:0]         lane_en;
   logic [31:0]        store_word;
   logic               lane_misaligned;
   logic               commit_write;
   logic               unused_addr_bits;

   logic [31:0]        mem [DEPTH_WORDS];

   assign req              = MemRead | MemWrite;
   assign accept           = (state == ST_IDLE) & req;
   assign unused_addr_bits = ^Address[31:IDX_W+2];

   // With LATENCY=1 the commit happens on the accept edge itself, before the
   // capture registers hold anything, so the RAM path looks at the live inputs
   // while IDLE and at the captured request otherwise.
   assign in_idle      = (state == ST_IDLE);
   assign cur_store    = in_idle ? MemWrite             : store_q;
   assign cur_byte_sel = in_idle ? ByteSel              : byte_sel_q;
   assign cur_sign_ext = in_idle ? SignExt              : sign_ext_q;
   assign cur_addr     = in_idle ? Address[IDX_W+1:0]   : addr_q;
   assign cur_wdata    = in_idle ? WriteData            : wdata_q;
   assign word_idx     = cur_addr[IDX_W+1:2];
   assign ram_word     = mem[word_idx];

   byte_lane_align u_align (
      .byte_sel   (cur_byte_sel),
      .sign_ext   (cur_sign_ext),
      .addr_lo    (cur_addr[1:0]),
      .write_data (cur_wdata),
      .ram_word   (ram_word),
      .load_data  (load_data),
      .lane_en    (lane_en),
      .store_word (store_word),
      .misaligned (lane_misaligned)
   );

   // State and latency counter register.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic; enter_resp marks the edge on which the RAM is committed.
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      enter_resp = 1'b0;
      Stall      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               Stall = 1'b1;
               if (LATENCY == 1) begin
                  next_state = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  next_state = ST_BUSY;
                  cnt_next   = CNT_INIT;
               end
            end
         end
         ST_BUSY: begin
            Stall = 1'b1;
            if (cnt == '0) begin
               next_state = ST_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_next = cnt - LAT_W'(1);
            end
         end
         ST_RESP: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Request capture on accept; later input changes are ignored.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         store_q    <= 1'b0;
         byte_sel_q <= BS_WORD;
         sign_ext_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else if (accept) begin
         store_q    <= MemWrite;
         byte_sel_q <= ByteSel;
         sign_ext_q <= SignExt;
         addr_q     <= Address[IDX_W+1:0];
         wdata_q    <= WriteData;
      end
   end

   // A reset landing on the commit edge abandons the store.
   assign commit_write = enter_resp & cur_store & ~lane_misaligned & ~Reset;

   // Data RAM: byte-lane writes, contents survive Reset.
   always_ff @(posedge Clock) begin
      if (commit_write) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
               mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
            end
         end
      end
   end

   // Registered response: valid only for the single RESP cycle, zero otherwise.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         Ready      <= 1'b0;
         ReadData   <= '0;
         Misaligned <= 1'b0;
      end else if (enter_resp) begin
         Ready      <= 1'b1;
         Misaligned <= lane_misaligned;
         ReadData   <= (cur_store | lane_misaligned) ? '0 : load_data;
      end else begin
         Ready      <= 1'b0;
         ReadData   <= '0;
         Misaligned <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Drives two responders (LATENCY=2 as dut 0, LATENCY=1 as dut 1) through
// stores, loads, sub-word access, misalignment, reset mid-request and index
// wrap. Expected responses go into a per-dut queue when a request is driven
// and are popped when that dut raises Ready.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

   typedef struct {
      logic [31:0] data;
      logic        mis;
      int          due;
      int          id;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_read   [2];
   logic        mem_write  [2];
   logic [1:0]  byte_sel   [2];
   logic        sign_ext   [2];
   logic [31:0] address    [2];
   logic [31:0] write_data [2];
   logic [31:0] read_data  [2];
   logic        ready      [2];
   logic        stall      [2];
   logic        misaligned [2];

   exp_t sb0[$];
   exp_t sb1[$];
   int   assert_count = 0;
   int   fail_count   = 0;
   int   cycle        = 0;
   int   txn_id       = 0;
   bit   mon_en       = 1'b0;

   data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
      .Clock(clock), .Reset(reset),
      .MemRead(mem_read[0]), .MemWrite(mem_write[0]), .ByteSel(byte_sel[0]),
      .SignExt(sign_ext[0]), .Address(address[0]), .WriteData(write_data[0]),
      .ReadData(read_data[0]), .Ready(ready[0]), .Stall(stall[0]),
      .Misaligned(misaligned[0])
   );

   data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
      .Clock(clock), .Reset(reset),
      .MemRead(mem_read[1]), .MemWrite(mem_write[1]), .ByteSel(byte_sel[1]),
      .SignExt(sign_ext[1]), .Address(address[1]), .WriteData(write_data[1]),
      .ReadData(read_data[1]), .Ready(ready[1]), .Stall(stall[1]),
      .Misaligned(misaligned[1])
   );

   // Free-running clock and cycle counter (cycle advances on each rising edge).
   always #5 clock = ~clock;

   always @(posedge clock) cycle++;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Pop the oldest expectation for a dut that just raised Ready.
   task automatic scoreResponse(input int d);
      exp_t e;
      bit   have = 1'b0;
      if (d == 0 && sb0.size() > 0) begin
         e = sb0.pop_front();
         have = 1'b1;
      end else if (d == 1 && sb1.size() > 0) begin
         e = sb1.pop_front();
         have = 1'b1;
      end
      if (!have) begin
         checkOutput($sformatf("dut%0d_spurious_ready", d), 32'(ready[d]), 32'd0);
      end else begin
         checkOutput($sformatf("dut%0d_t%0d_data", d, e.id), read_data[d], e.data);
         checkOutput($sformatf("dut%0d_t%0d_mis", d, e.id), 32'(misaligned[d]), 32'(e.mis));
         checkOutput($sformatf("dut%0d_t%0d_cycle", d, e.id), 32'(cycle), 32'(e.due));
      end
   endtask

   // Monitor: score every Ready, and require quiet outputs between pulses.
   always @(negedge clock) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            if (ready[d]) begin
               scoreResponse(d);
            end else begin
               checkOutput($sformatf("dut%0d_idle_data", d), read_data[d], 32'd0);
               checkOutput($sformatf("dut%0d_idle_mis", d), 32'(misaligned[d]), 32'd0);
            end
         end
      end
   end

   // Present one request to dut d, record its expected response, and follow
   // the handshake until the Ready cycle. Inputs are scrambled while busy.
   task automatic applyStimulus(input int d, input logic wr, input logic rd,
                                input logic [1:0] bs, input logic sx,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_data, input logic exp_mis);
      int   lat;
      exp_t e;
      lat = (d == 0) ? 2 : 1;
      @(negedge clock);
      mem_write[d]  = wr;
      mem_read[d]   = rd;
      byte_sel[d]   = bs;
      sign_ext[d]   = sx;
      address[d]    = addr;
      write_data[d] = wdata;
      e.data = exp_data;
      e.mis  = exp_mis;
      e.due  = cycle + lat;
      e.id   = txn_id;
      txn_id++;
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
      #1;
      checkOutput($sformatf("dut%0d_t%0d_stall_accept", d, e.id), 32'(stall[d]), 32'd1);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clock);
         if (k < lat) begin
            checkOutput($sformatf("dut%0d_t%0d_stall_busy", d, e.id), 32'(stall[d]), 32'd1);
            mem_read[d]   = 1'b0;
            mem_write[d]  = 1'b0;
            address[d]    = $urandom;
            write_data[d] = $urandom;
            byte_sel[d]   = 2'($urandom_range(3, 0));
            sign_ext[d]   = ~sx;
         end else begin
            checkOutput($sformatf("dut%0d_t%0d_stall_resp", d, e.id), 32'(stall[d]), 32'd0);
            checkOutput($sformatf("dut%0d_t%0d_ready", d, e.id), 32'(ready[d]), 32'd1);
            mem_read[d]  = 1'b0;
            mem_write[d] = 1'b0;
         end
      end
   endtask

   // Store on dut 0 abandoned by a one-cycle reset in the cycle after accept.
   task automatic resetMidOp();
      @(negedge clock);
      mem_write[0]  = 1'b1;
      mem_read[0]   = 1'b0;
      byte_sel[0]   = 2'b00;
      address[0]    = 32'h30;
      write_data[0] = 32'hCAFEF00D;
      #1;
      checkOutput("rst_mid_stall_accept", 32'(stall[0]), 32'd1);
      @(negedge clock);
      mem_write[0] = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("rst_mid_stall_drop", 32'(stall[0]), 32'd0);
      checkOutput("rst_mid_no_ready", 32'(ready[0]), 32'd0);
      @(negedge clock);
      checkOutput("rst_mid_no_ready_late", 32'(ready[0]), 32'd0);
   endtask

   // Bounded run time: a hang is reported as a failure before stopping.
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence.
   initial begin
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         mem_read[d]   = 1'b0;
         mem_write[d]  = 1'b0;
         byte_sel[d]   = 2'b00;
         sign_ext[d]   = 1'b0;
         address[d]    = 32'h0;
         write_data[d] = 32'h0;
      end
      repeat (4) @(negedge clock);
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("dut%0d_reset_ready", d), 32'(ready[d]), 32'd0);
         checkOutput($sformatf("dut%0d_reset_stall", d), 32'(stall[d]), 32'd0);
         checkOutput($sformatf("dut%0d_reset_data", d), read_data[d], 32'd0);
         checkOutput($sformatf("dut%0d_reset_mis", d), 32'(misaligned[d]), 32'd0);
      end
      reset  = 1'b0;
      mon_en = 1'b1;

      // LATENCY=2: word store then load back
      applyStimulus(0, 1, 0, 2'b00, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
      applyStimulus(0, 0, 1, 2'b00, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0);

      // Sub-word loads on 0x11223344
      applyStimulus(0, 1, 0, 2'b00, 0, 32'h20, 32'h11223344, 32'h0, 0);
      applyStimulus(0, 0, 1, 2'b10, 1, 32'h23, 32'h0, 32'h00000011, 0);
      applyStimulus(0, 0, 1, 2'b01, 0, 32'h22, 32'h0, 32'h00001122, 0);

      // Byte store into lane 1, then sign/zero-extended reads of that lane
      applyStimulus(0, 1, 0, 2'b10, 0, 32'h21, 32'h123456FF, 32'h0, 0);
      applyStimulus(0, 0, 1, 2'b10, 1, 32'h21, 32'h0, 32'hFFFFFFFF, 0);
      applyStimulus(0, 0, 1, 2'b10, 0, 32'h21, 32'h0, 32'h000000FF, 0);
      applyStimulus(0, 0, 1, 2'b00, 0, 32'h20, 32'h0, 32'h1122FF44, 0);
      applyStimulus(0, 0, 1, 2'b01, 1, 32'h20, 32'h0, 32'hFFFFFF44, 0);

      // Upper-half store
      applyStimulus(0, 1, 0, 2'b01, 0, 32'h22, 32'hABCD5566, 32'h0, 0);
      applyStimulus(0, 0, 1, 2'b00, 0, 32'h20, 32'h0, 32'h5566FF44, 0);

      // Misaligned word load and half store leave the RAM untouched
      applyStimulus(0, 0, 1, 2'b00, 0, 32'h22, 32'h0, 32'h0, 1);
      applyStimulus(0, 0, 1, 2'b00, 0, 32'h20, 32'h0, 32'h5566FF44, 0);
      applyStimulus(0, 1, 0, 2'b01, 0, 32'h21, 32'h00009999, 32'h0, 1);
      applyStimulus(0, 0, 1, 2'b00, 0, 32'h20, 32'h0, 32'h5566FF44, 0);

      // Reserved size code acts as word; MemRead+MemWrite acts as store
      applyStimulus(0, 0, 1, 2'b11, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
      applyStimulus(0, 1, 1, 2'b00, 0, 32'h14, 32'h0BADF00D, 32'h0, 0);
      applyStimulus(0, 0, 1, 2'b00, 0, 32'h14, 32'h0, 32'h0BADF00D, 0);

      // Reset mid-store keeps the prior contents
      applyStimulus(0, 1, 0, 2'b00, 0, 32'h30, 32'h01234567, 32'h0, 0);
      resetMidOp();
      applyStimulus(0, 0, 1, 2'b00, 0, 32'h30, 32'h0, 32'h01234567, 0);

      // LATENCY=1: back-to-back traffic and index wrap
      applyStimulus(1, 1, 0, 2'b00, 0, 32'h10, 32'hA5A55A5A, 32'h0, 0);
      applyStimulus(1, 0, 1, 2'b00, 0, 32'h10, 32'h0, 32'hA5A55A5A, 0);
      applyStimulus(1, 0, 1, 2'b00, 0, 32'h1010, 32'h0, 32'hA5A55A5A, 0);
      applyStimulus(1, 0, 1, 2'b10, 1, 32'h13, 32'h0, 32'hFFFFFFA5, 0);
      applyStimulus(1, 0, 1, 2'b01, 0, 32'h12, 32'h0, 32'h0000A5A5, 0);

      repeat (3) @(negedge clock);
      checkOutput("sb0_drained", 32'(sb0.size()), 32'd0);
      checkOutput("sb1_drained", 32'(sb1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
